// File: rtl/uart_pkg.sv
// +--------------------------------------------------------------------------+
// | uart_pkg: shared UART timing constants, receiver state type, helpers.     |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

package uart_pkg;

   localparam int CLK_HZ       = 100_000_000;
   localparam int BIT_RATE     = 9600;
   localparam int CLKS_PER_BIT = CLK_HZ / BIT_RATE;
   localparam int HALF_BIT     = CLKS_PER_BIT / 2;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      BRK   = 3'd4
   } rx_state_e;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

`default_nettype wire

// File: rtl/uart_sync2.sv
// +--------------------------------------------------------------------------+
// | uart_sync2: two-flop synchronizer for an asynchronous level input.        |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module uart_sync2 #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk_i,
   input  logic nreset_i,
   input  logic d_i,
   output logic q_o
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;

   always_comb begin
      meta_d = d_i;
      sync_d = meta_q;
   end

   always_ff @(posedge clk_i) begin
      if (!nreset_i) begin
         meta_q <= RESET_VAL;
         sync_q <= RESET_VAL;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// +--------------------------------------------------------------------------+
// | uart_rx: 8N1 UART receiver with valid/ready output and error pulses.      |
// | Optional 2-of-3 majority sampling: UART_RX_MAJORITY_EN.   Rev 1.0         |
// +--------------------------------------------------------------------------+
`default_nettype none

module uart_rx
   import uart_pkg::*;
#(
   parameter int CLK_HZ   = uart_pkg::CLK_HZ,
   parameter int BIT_RATE = uart_pkg::BIT_RATE
) (
   input  logic       clk_i,
   input  logic       nreset_i,
   input  logic       rx_i,
   output logic [7:0] rx_data_o,
   output logic       valid,
   input  logic       ready,
   output logic       frame_err_o,
   output logic       overrun_o
);

   localparam int CLKS_PER_BIT = CLK_HZ / BIT_RATE;
   localparam int HALF_BIT     = CLKS_PER_BIT / 2;
   localparam int CNT_W        = $clog2(CLKS_PER_BIT) + 1;

   // Majority voting centres its window on the nominal instant, so the
   // start decision lands one clock later; later bits keep the CLKS_PER_BIT pitch.
`ifdef UART_RX_MAJORITY_EN
   localparam int START_TGT = HALF_BIT;
`else
   localparam int START_TGT = HALF_BIT - 1;
`endif
   localparam int DATA_TGT = CLKS_PER_BIT - 1;

   logic             rx_s;
   logic             bit_val;
   logic             bit_tick;
   logic             byte_done;

   rx_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_cnt_q, bit_cnt_d;
   logic [7:0]       shift_q, shift_d;
   logic [7:0]       data_q, data_d;
   logic             valid_q, valid_d;
   logic             frame_err_q, frame_err_d;
   logic             overrun_q, overrun_d;

   uart_sync2 #(
      .RESET_VAL (1'b1)
   ) u_sync (
      .clk_i    (clk_i),
      .nreset_i (nreset_i),
      .d_i      (rx_i),
      .q_o      (rx_s)
   );

`ifdef UART_RX_MAJORITY_EN
   logic [1:0] hist_q, hist_d;

   always_comb begin
      hist_d  = {hist_q[0], rx_s};
      bit_val = maj3(rx_s, hist_q[0], hist_q[1]);
   end

   always_ff @(posedge clk_i) begin
      if (!nreset_i) begin
         hist_q <= 2'b11;
      end else begin
         hist_q <= hist_d;
      end
   end
`else
   assign bit_val = rx_s;
`endif

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      data_d      = data_q;
      valid_d     = valid_q;
      frame_err_d = 1'b0;
      overrun_d   = 1'b0;
      bit_tick    = 1'b0;
      byte_done   = 1'b0;

      case (state_q)
         IDLE: begin
            if (!rx_s) begin
               state_d = START;
            end
         end
         START: begin
            if (cnt_q == CNT_W'(START_TGT)) begin
               state_d = bit_val ? IDLE : DATA;
            end
         end
         DATA: begin
            if (cnt_q == CNT_W'(DATA_TGT)) begin
               bit_tick           = 1'b1;
               shift_d[bit_cnt_q] = bit_val;
               if (bit_cnt_q == 3'd7) begin
                  bit_cnt_d = 3'd0;
                  state_d   = STOP;
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end
         end
         STOP: begin
            if (cnt_q == CNT_W'(DATA_TGT)) begin
               if (bit_val) begin
                  byte_done = 1'b1;
                  state_d   = IDLE;
               end else begin
                  frame_err_d = 1'b1;
                  state_d     = BRK;
               end
            end
         end
         BRK: begin
            if (rx_s) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (state_q == IDLE || state_d != state_q || bit_tick) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end

      // A fresh byte displaces the held one only if it is being consumed now.
      if (byte_done) begin
         if (!valid_q || ready) begin
            data_d  = shift_q;
            valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end else if (valid_q && ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!nreset_i) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         bit_cnt_q   <= 3'd0;
         shift_q     <= 8'h00;
         data_q      <= 8'h00;
         valid_q     <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
      end
   end

   assign rx_data_o   = data_q;
   assign valid       = valid_q;
   assign frame_err_o = frame_err_q;
   assign overrun_o   = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// +--------------------------------------------------------------------------+
// | tb_uart_rx: randomized self-checking bench for uart_rx (fast baud).       |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_uart_rx;

   localparam int CLK_HZ   = 1_600_000;
   localparam int BIT_RATE = 100_000;
   localparam int CPB      = CLK_HZ / BIT_RATE;
   localparam int HALF     = CPB / 2;
`ifdef UART_RX_MAJORITY_EN
   localparam int MAJ_LAT = 1;
`else
   localparam int MAJ_LAT = 0;
`endif
   // Line edge in cycle k -> 2 sync stages -> 9.5 bit times to stop centre -> register.
   localparam int EVT_LAT = 3 + HALF + 9 * CPB + MAJ_LAT;

   logic       clk = 1'b0;
   logic       nreset_i;
   logic       rx_i;
   logic [7:0] rx_data_o;
   logic       valid;
   logic       ready;
   logic       frame_err_o;
   logic       overrun_o;

   always #5 clk = ~clk;

   uart_rx #(
      .CLK_HZ   (CLK_HZ),
      .BIT_RATE (BIT_RATE)
   ) dut (
      .clk_i       (clk),
      .nreset_i    (nreset_i),
      .rx_i        (rx_i),
      .rx_data_o   (rx_data_o),
      .valid       (valid),
      .ready       (ready),
      .frame_err_o (frame_err_o),
      .overrun_o   (overrun_o)
   );

   typedef struct {
      int         edge_n;
      bit         ferr;
      logic [7:0] data;
   } evt_t;

   evt_t       evq[$];
   evt_t       cur;
   int         cyc = 0;
   int         checks = 0;
   int         failures = 0;
   bit         m_live = 1'b0;
   logic       m_valid = 1'b0;
   logic [7:0] m_data = 8'h00;
   logic       m_ferr = 1'b0;
   logic       m_ovr = 1'b0;
   logic       prev_valid = 1'b0;
   int         valid_rises = 0;
   int         ferr_pulses = 0;
   int         ovr_pulses = 0;
   int         last_rise_cyc = 0;

   // Frame-level reference: each frame resolves at one known edge into a byte
   // or a framing error, then the holding-register handshake rules apply.
   always @(posedge clk) begin
      cyc++;
      m_ferr = 1'b0;
      m_ovr  = 1'b0;
      if (!nreset_i) begin
         m_valid = 1'b0;
         m_data  = 8'h00;
         evq.delete();
         m_live  = 1'b1;
      end else begin
         bit new_byte;
         new_byte = 1'b0;
         if (evq.size() > 0 && evq[0].edge_n == cyc) begin
            cur = evq.pop_front();
            if (cur.ferr) m_ferr = 1'b1;
            else          new_byte = 1'b1;
         end
         if (new_byte) begin
            if (!m_valid || ready) begin
               m_data  = cur.data;
               m_valid = 1'b1;
            end else begin
               m_ovr = 1'b1;
            end
         end else if (m_valid && ready) begin
            m_valid = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (m_live) begin
         checks++;
         if ({valid, rx_data_o, frame_err_o, overrun_o} !== {m_valid, m_data, m_ferr, m_ovr}) begin
            failures++;
            $display("FAIL outputs cyc=%0d got valid=%b data=%h ferr=%b ovr=%b required valid=%b data=%h ferr=%b ovr=%b",
                     cyc, valid, rx_data_o, frame_err_o, overrun_o, m_valid, m_data, m_ferr, m_ovr);
         end
         if (valid === 1'b1 && prev_valid !== 1'b1) begin
            valid_rises++;
            last_rise_cyc = cyc;
         end
         if (frame_err_o === 1'b1) ferr_pulses++;
         if (overrun_o === 1'b1) ovr_pulses++;
         prev_valid = valid;
      end
   end

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d (0x%0h) required=%0d (0x%0h)", name, got, got, exp, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      rx_i = 1'b1;
      repeat (n) tick();
   endtask

   // stop_low: 0 = normal stop, N>0 = stop (and line) held low N bit times.
   // glitch: invert the line for one clock at every bit centre.
   // rst_bit: pulse reset for one clock inside that bit (-1 = none).
   task automatic send(input logic [7:0] b, input int stop_low, input bit glitch,
                       input bit rnd_ready, input int rst_bit, output int start_cyc);
      logic [9:0] fr;
      logic       v;
      evt_t       e;
      fr        = {1'b1, b, 1'b0};
      start_cyc = cyc;
      e.edge_n  = cyc + EVT_LAT;
      e.ferr    = (stop_low > 0);
      e.data    = b;
      evq.push_back(e);
      for (int j = 0; j < 10; j++) begin
         for (int c = 0; c < CPB; c++) begin
            v = fr[j];
            if (j == 9 && stop_low > 0) v = 1'b0;
            if (glitch && c == HALF) v = ~v;
            rx_i     = v;
            nreset_i = !(j == rst_bit && c == 2);
            if (rnd_ready) ready = 1'($urandom_range(0, 1));
            tick();
         end
      end
      nreset_i = 1'b1;
      if (stop_low > 1) begin
         rx_i = 1'b0;
         repeat ((stop_low - 1) * CPB) tick();
      end
      rx_i = 1'b1;
   endtask

   initial begin
      int k;
      int r0, f0, o0;
      nreset_i = 1'b0;
      rx_i     = 1'b1;
      ready    = 1'b1;
      repeat (3) tick();
      chk("reset_valid", int'(valid), 0);
      chk("reset_data", int'(rx_data_o), 8'h00);
      chk("reset_flags", int'({frame_err_o, overrun_o}), 0);
      nreset_i = 1'b1;
      idle(5);

      // Single byte, consumer always ready.
      r0 = valid_rises; f0 = ferr_pulses; o0 = ovr_pulses;
      send(8'hA5, 0, 1'b0, 1'b0, -1, k);
      idle(CPB);
      chk("a5_valid_rises", valid_rises - r0, 1);
      chk("a5_data", int'(rx_data_o), 8'hA5);
      chk("a5_latency", last_rise_cyc - k, 3 + 8 + 9 * 16 + MAJ_LAT);
      chk("a5_flags", (ferr_pulses - f0) + (ovr_pulses - o0), 0);

      // Two bytes with no consumer: second one is an overrun.
      ready = 1'b0;
      o0 = ovr_pulses;
      send(8'h3C, 0, 1'b0, 1'b0, -1, k);
      send(8'hC3, 0, 1'b0, 1'b0, -1, k);
      idle(CPB);
      chk("ovr_valid_held", int'(valid), 1);
      chk("ovr_data_kept", int'(rx_data_o), 8'h3C);
      chk("ovr_pulses", ovr_pulses - o0, 1);
      ready = 1'b1;
      idle(4);
      chk("ovr_drained", int'(valid), 0);

      // Break: stop bit low for three bit times.
      r0 = valid_rises; f0 = ferr_pulses;
      send(8'h55, 3, 1'b0, 1'b0, -1, k);
      idle(2 * CPB);
      chk("brk_ferr_pulses", ferr_pulses - f0, 1);
      chk("brk_no_valid", valid_rises - r0, 0);
      send(8'h0F, 0, 1'b0, 1'b0, -1, k);
      idle(CPB);
      chk("after_brk_data", int'(rx_data_o), 8'h0F);
      chk("after_brk_rises", valid_rises - r0, 1);

      // Short low pulse shorter than half a bit is rejected.
      r0 = valid_rises; f0 = ferr_pulses; o0 = ovr_pulses;
      rx_i = 1'b0;
      repeat (HALF / 2) tick();
      idle(3 * CPB);
      chk("glitch_quiet", (valid_rises - r0) + (ferr_pulses - f0) + (ovr_pulses - o0), 0);

      // Reset in the middle of bit 4 loses the frame; next frame is intact.
      r0 = valid_rises;
      send(8'hFF, 0, 1'b0, 1'b0, 5, k);
      idle(CPB);
      chk("rst_no_valid", valid_rises - r0, 0);
      send(8'h81, 0, 1'b0, 1'b0, -1, k);
      idle(CPB);
      chk("rst_next_data", int'(rx_data_o), 8'h81);

`ifdef UART_RX_MAJORITY_EN
      send(8'h96, 0, 1'b1, 1'b0, -1, k);
      idle(CPB);
      chk("maj_glitch_data", int'(rx_data_o), 8'h96);
`endif

      // Randomized traffic with random consumer back-pressure and gaps.
      for (int n = 0; n < 24; n++) begin
         send(8'($urandom_range(0, 255)), ($urandom_range(0, 7) == 0) ? 1 : 0,
              1'b0, 1'b1, -1, k);
         idle($urandom_range(0, 20));
      end
      ready = 1'b1;
      idle(EVT_LAT);
      chk("events_drained", evq.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
